// File: rtl/data_repeater_fifo_frm.sv
// Frame-based repeater FIFO: each written frame is replayed (R+1) times before
// its storage is released. Single clock, registered read data.
module data_repeater_fifo_frm #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int REPEAT_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    flush_i,
    input  logic                    fifo_wr_i,
    input  logic [DATA_WIDTH-1:0]   fifo_wr_dat_i,
    input  logic                    fifo_wr_last_i,
    output logic                    fifo_wr_full_o,
    output logic                    fifo_wr_overflow_o,
    output logic [ADDR_WIDTH:0]     fifo_level_o,
    input  logic [REPEAT_WIDTH-1:0] repeat_cnt_i,
    input  logic                    fifo_rd_i,
    output logic                    fifo_empty_o,
    output logic [DATA_WIDTH-1:0]   fifo_rd_dat_o,
    output logic                    fifo_rd_dat_valid_o,
    output logic                    fifo_rd_last_o,
    output logic [REPEAT_WIDTH-1:0] fifo_rd_pass_o
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   PTR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LVL_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [REPEAT_WIDTH-1:0] PASS_ONE  = {{(REPEAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REPEAT_WIDTH-1:0] PASS_ZERO = {REPEAT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]   DAT_ZERO  = {DATA_WIDTH{1'b0}};

    // Word storage: bit DATA_WIDTH carries the end-of-frame flag.
    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     base_ptr_q, base_ptr_d;
    logic [REPEAT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [REPEAT_WIDTH-1:0] r_lat_q, r_lat_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   rd_dat_q, rd_dat_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic [REPEAT_WIDTH-1:0] rd_pass_q, rd_pass_d;

    logic [ADDR_WIDTH:0]     level_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    wr_acc_s;
    logic                    rd_acc_s;
    logic [DATA_WIDTH:0]     rd_word_s;
    logic                    frame_start_s;
    logic [REPEAT_WIDTH-1:0] r_eff_s;

    // Status and accept decode from the pre-edge register state.
    always_comb begin
        level_s       = wr_ptr_q - base_ptr_q;
        full_s        = (level_s == LVL_FULL);
        empty_s       = (rd_ptr_q == wr_ptr_q);
        wr_acc_s      = fifo_wr_i & ~full_s;
        rd_acc_s      = fifo_rd_i & ~empty_s;
        rd_word_s     = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        // The live repeat input applies on the very first read of a frame so
        // single-word frames see it before it could be latched.
        frame_start_s = (rd_ptr_q == base_ptr_q) && (pass_cnt_q == PASS_ZERO);
        if (frame_start_s) begin
            r_eff_s = repeat_cnt_i;
        end else begin
            r_eff_s = r_lat_q;
        end
    end

    // Next-state for pointers, pass counter, overflow and read output stage.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        base_ptr_d = base_ptr_q;
        pass_cnt_d = pass_cnt_q;
        r_lat_d    = r_lat_q;
        overflow_d = overflow_q;
        rd_dat_d   = rd_dat_q;
        rd_last_d  = rd_last_q;
        rd_pass_d  = rd_pass_q;
        rd_valid_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            base_ptr_d = PTR_ZERO;
            pass_cnt_d = PASS_ZERO;
            r_lat_d    = PASS_ZERO;
            overflow_d = 1'b0;
            rd_dat_d   = DAT_ZERO;
            rd_last_d  = 1'b0;
            rd_pass_d  = PASS_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (fifo_wr_i) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            if (rd_acc_s) begin
                rd_valid_d = 1'b1;
                rd_dat_d   = rd_word_s[DATA_WIDTH-1:0];
                rd_last_d  = rd_word_s[DATA_WIDTH];
                rd_pass_d  = pass_cnt_q;
                if (frame_start_s) begin
                    r_lat_d = repeat_cnt_i;
                end else begin
                    r_lat_d = r_lat_q;
                end
                if (rd_word_s[DATA_WIDTH]) begin
                    if (pass_cnt_q < r_eff_s) begin
                        rd_ptr_d   = base_ptr_q;
                        pass_cnt_d = pass_cnt_q + PASS_ONE;
                    end else begin
                        base_ptr_d = rd_ptr_q + PTR_ONE;
                        rd_ptr_d   = rd_ptr_q + PTR_ONE;
                        pass_cnt_d = PASS_ZERO;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
            end else begin
                rd_valid_d = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            base_ptr_q <= PTR_ZERO;
            pass_cnt_q <= PASS_ZERO;
            r_lat_q    <= PASS_ZERO;
            overflow_q <= 1'b0;
            rd_dat_q   <= DAT_ZERO;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_pass_q  <= PASS_ZERO;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            base_ptr_q <= base_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            r_lat_q    <= r_lat_d;
            overflow_q <= overflow_d;
            rd_dat_q   <= rd_dat_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_pass_q  <= rd_pass_d;
        end
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc_s && !flush_i) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {fifo_wr_last_i, fifo_wr_dat_i};
        end
    end

    assign fifo_wr_full_o      = full_s;
    assign fifo_wr_overflow_o  = overflow_q;
    assign fifo_level_o        = level_s;
    assign fifo_empty_o        = empty_s;
    assign fifo_rd_dat_o       = rd_dat_q;
    assign fifo_rd_dat_valid_o = rd_valid_q;
    assign fifo_rd_last_o      = rd_last_q;
    assign fifo_rd_pass_o      = rd_pass_q;

endmodule

// File: tb/tb_data_repeater_fifo_frm.sv
// Scoreboard bench for data_repeater_fifo_frm: stimulus pushes expected read
// words into a queue, a negedge monitor pops and compares on every valid pulse.
module tb_data_repeater_fifo_frm;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic        fifo_wr_i;
    logic [31:0] fifo_wr_dat_i;
    logic        fifo_wr_last_i;
    logic        fifo_wr_full_o;
    logic        fifo_wr_overflow_o;
    logic [4:0]  fifo_level_o;
    logic [7:0]  repeat_cnt_i;
    logic        fifo_rd_i;
    logic        fifo_empty_o;
    logic [31:0] fifo_rd_dat_o;
    logic        fifo_rd_dat_valid_o;
    logic        fifo_rd_last_o;
    logic [7:0]  fifo_rd_pass_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [40:0] exp_q [$];

    data_repeater_fifo_frm dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .flush_i             (flush_i),
        .fifo_wr_i           (fifo_wr_i),
        .fifo_wr_dat_i       (fifo_wr_dat_i),
        .fifo_wr_last_i      (fifo_wr_last_i),
        .fifo_wr_full_o      (fifo_wr_full_o),
        .fifo_wr_overflow_o  (fifo_wr_overflow_o),
        .fifo_level_o        (fifo_level_o),
        .repeat_cnt_i        (repeat_cnt_i),
        .fifo_rd_i           (fifo_rd_i),
        .fifo_empty_o        (fifo_empty_o),
        .fifo_rd_dat_o       (fifo_rd_dat_o),
        .fifo_rd_dat_valid_o (fifo_rd_dat_valid_o),
        .fifo_rd_last_o      (fifo_rd_last_o),
        .fifo_rd_pass_o      (fifo_rd_pass_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] d, input logic l, input logic [7:0] p);
        exp_q.push_back({l, p, d});
    endtask

    task automatic write_word(input logic [31:0] d, input logic l);
        fifo_wr_i      = 1'b1;
        fifo_wr_dat_i  = d;
        fifo_wr_last_i = l;
        tick();
        fifo_wr_i      = 1'b0;
        fifo_wr_last_i = 1'b0;
    endtask

    task automatic read_word();
        fifo_rd_i = 1'b1;
        tick();
        fifo_rd_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, fifo_rd_dat_valid_o}, 64'd0);
        chk({tag, "_dat"}, {32'd0, fifo_rd_dat_o}, 64'd0);
        chk({tag, "_last"}, {63'd0, fifo_rd_last_o}, 64'd0);
        chk({tag, "_pass"}, {56'd0, fifo_rd_pass_o}, 64'd0);
        chk({tag, "_empty"}, {63'd0, fifo_empty_o}, 64'd1);
        chk({tag, "_full"}, {63'd0, fifo_wr_full_o}, 64'd0);
        chk({tag, "_level"}, {59'd0, fifo_level_o}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, fifo_wr_overflow_o}, 64'd0);
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk_i) begin
        if (reset_n_i && fifo_rd_dat_valid_o) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL rd_unexpected: got dat=%0h last=%0b pass=%0d expected no valid",
                         fifo_rd_dat_o, fifo_rd_last_o, fifo_rd_pass_o);
            end else begin
                chk("rd_word", {23'd0, fifo_rd_last_o, fifo_rd_pass_o, fifo_rd_dat_o},
                    {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0; flush_i = 1'b0; fifo_wr_i = 1'b0; fifo_wr_dat_i = 32'd0;
        fifo_wr_last_i = 1'b0; repeat_cnt_i = 8'd0; fifo_rd_i = 1'b0;
        #2;
        chk_reset_outputs("rst0");
        #10 reset_n_i = 1'b1;
        tick();

        // Plain FIFO, R=0
        for (int i = 1; i <= 10; i++) write_word(32'(i), (i == 10));
        chk("t1_level10", {59'd0, fifo_level_o}, 64'd10);
        for (int i = 1; i <= 10; i++) begin
            exp_push(32'(i), (i == 10), 8'd0);
            read_word();
        end
        tick();
        chk("t1_empty", {63'd0, fifo_empty_o}, 64'd1);
        chk("t1_level0", {59'd0, fifo_level_o}, 64'd0);

        // R=2, three-word frame
        repeat_cnt_i = 8'd2;
        write_word(32'hA, 1'b0); write_word(32'hB, 1'b0); write_word(32'hC, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 3; w++) begin
                exp_push(32'hA + 32'(w), (w == 2), 8'(p));
                read_word();
                if (p == 2 && w == 2) chk("t2_level_freed", {59'd0, fifo_level_o}, 64'd0);
                else chk("t2_level_held", {59'd0, fifo_level_o}, 64'd3);
            end
        end

        // Fill, overflow, release after final pass
        repeat_cnt_i = 8'd1;
        for (int i = 0; i < 16; i++) write_word(32'd100 + 32'(i), (i == 7 || i == 15));
        chk("t3_full", {63'd0, fifo_wr_full_o}, 64'd1);
        chk("t3_ovf_pre", {63'd0, fifo_wr_overflow_o}, 64'd0);
        write_word(32'd999, 1'b1);
        chk("t3_full17", {63'd0, fifo_wr_full_o}, 64'd1);
        chk("t3_ovf", {63'd0, fifo_wr_overflow_o}, 64'd1);
        chk("t3_level16", {59'd0, fifo_level_o}, 64'd16);
        for (int i = 0; i < 8; i++) begin
            exp_push(32'd100 + 32'(i), (i == 7), 8'd0);
            read_word();
        end
        chk("t3_full_after_pass0", {63'd0, fifo_wr_full_o}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            exp_push(32'd100 + 32'(i), (i == 7), 8'd1);
            read_word();
        end
        chk("t3_full_released", {63'd0, fifo_wr_full_o}, 64'd0);
        chk("t3_level8", {59'd0, fifo_level_o}, 64'd8);
        for (int p = 0; p < 2; p++) begin
            for (int i = 8; i < 16; i++) begin
                exp_push(32'd100 + 32'(i), (i == 15), 8'(p));
                read_word();
            end
        end
        chk("t3_drained", {63'd0, fifo_empty_o}, 64'd1);
        chk("t3_ovf_sticky", {63'd0, fifo_wr_overflow_o}, 64'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk_reset_outputs("t3_flush");

        // Single-word frame, R taken from the first read only
        repeat_cnt_i = 8'd0;
        write_word(32'h5A5A_0001, 1'b1);
        repeat_cnt_i = 8'd3;
        exp_push(32'h5A5A_0001, 1'b1, 8'd0);
        read_word();
        repeat_cnt_i = 8'd0;
        for (int p = 1; p <= 3; p++) begin
            exp_push(32'h5A5A_0001, 1'b1, 8'(p));
            read_word();
        end
        tick();
        chk("t4_empty", {63'd0, fifo_empty_o}, 64'd1);
        chk("t4_level0", {59'd0, fifo_level_o}, 64'd0);

        // Slow writer, continuous reader, R=1
        repeat_cnt_i = 8'd1;
        for (int p = 0; p < 2; p++)
            for (int w = 0; w < 3; w++) exp_push(32'hD0 + 32'(w), (w == 2), 8'(p));
        fork
            begin
                for (int w = 0; w < 3; w++) begin
                    write_word(32'hD0 + 32'(w), (w == 2));
                    repeat (2) tick();
                end
            end
            begin
                fifo_rd_i = 1'b1;
                repeat (30) tick();
                fifo_rd_i = 1'b0;
            end
        join
        tick();
        chk("t5_all_words_seen", 64'(exp_q.size()), 64'd0);
        chk("t5_empty", {63'd0, fifo_empty_o}, 64'd1);
        chk("t5_level0", {59'd0, fifo_level_o}, 64'd0);

        // Async reset during pass 1 of 2
        repeat_cnt_i = 8'd2;
        write_word(32'hE0, 1'b0); write_word(32'hE1, 1'b1);
        exp_push(32'hE0, 1'b0, 8'd0); read_word();
        exp_push(32'hE1, 1'b1, 8'd0); read_word();
        exp_push(32'hE0, 1'b0, 8'd1); read_word();
        tick();
        #2 reset_n_i = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        #10 reset_n_i = 1'b1;
        tick();
        chk_reset_outputs("t6_post_rst");

        // Same replay position, plus overflow, cleared by flush
        write_word(32'hF0, 1'b0); write_word(32'hF1, 1'b1);
        exp_push(32'hF0, 1'b0, 8'd0); read_word();
        exp_push(32'hF1, 1'b1, 8'd0); read_word();
        exp_push(32'hF0, 1'b0, 8'd1); read_word();
        tick();
        for (int i = 0; i < 15; i++) write_word(32'h300 + 32'(i), 1'b1);
        chk("t6_ovf_set", {63'd0, fifo_wr_overflow_o}, 64'd1);
        chk("t6_full", {63'd0, fifo_wr_full_o}, 64'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk_reset_outputs("t6_flush");

        tick();
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/data_repeater_fifo_frm.md
Name: data_repeater_fifo_frm

Overview:
Single-clock, parametrised successor of the data repeater FIFO. Words are written in frames, with the last word of each frame flagged. Each frame is read out (R+1) times, where R is sampled per frame. Buffer space is released only after the final pass. The block sits between the DMA bus write path and test/readout consumers that need deterministic replay of captured data blocks.

Parameters:
DATA_WIDTH, 32, width of data word
ADDR_WIDTH, 4, log2 of depth (DEPTH = 2^ADDR_WIDTH = 16 words)
REPEAT_WIDTH, 8, width of repeat count R

Ports:
clk_i  in  1  single clock, all logic on rising edge
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of all pointers, pass counter and overflow flag
fifo_wr_i  in  1  write strobe
fifo_wr_dat_i  in  DATA_WIDTH  write data
fifo_wr_last_i  in  1  marks the current write word as the last of its frame
fifo_wr_full_o  out  1  no free word; writes are ignored
fifo_wr_overflow_o  out  1  sticky: a write was attempted while full
fifo_level_o  out  ADDR_WIDTH+1  words held, counting words retained for replay
repeat_cnt_i  in  REPEAT_WIDTH  extra passes R for the frame about to start
fifo_rd_i  in  1  read strobe
fifo_empty_o  out  1  no readable word at the read pointer
fifo_rd_dat_o  out  DATA_WIDTH  read data, registered
fifo_rd_dat_valid_o  out  1  one-cycle pulse qualifying fifo_rd_dat_o
fifo_rd_last_o  out  1  qualified with valid: word is the last of its frame
fifo_rd_pass_o  out  REPEAT_WIDTH  qualified with valid: pass index of the word (0..R)

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array; the extra bit holds the last flag. The array is not reset.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH:
  - wr_ptr: next word to write.
  - rd_ptr: next word to read.
  - base_ptr: first word of the current frame, i.e. the oldest retained word.
- Status (combinational from registers):
  - level = wr_ptr - base_ptr
  - full = (level == DEPTH)
  - empty = (rd_ptr == wr_ptr)
- Reset (async, reset_n_i=0) and flush_i=1 both apply the following. flush_i has priority over wr/rd in the same cycle.
  - All pointers = 0; pass_cnt = 0; R_lat = 0; overflow = 0.
  - fifo_rd_dat_o = 0; valid = 0; last = 0; pass_o = 0.
  - empty = 1; full = 0; level = 0.
- Write accept = fifo_wr_i & ~full:
  - mem[wr_ptr] <= {last_i, dat_i}; wr_ptr + 1.
  - fifo_wr_i & full: word dropped; overflow <= 1 (sticky until flush or reset).
- Read accept = fifo_rd_i & ~empty. On accept:
  - Next edge: fifo_rd_dat_o and fifo_rd_last_o from mem[rd_ptr], fifo_rd_pass_o = pass_cnt, and valid pulses 1 for one cycle. Read latency is 1 cycle.
  - fifo_rd_i while empty: no effect; valid = 0.
- Repeat latch:
  - On an accepted read with rd_ptr == base_ptr and pass_cnt == 0, R_lat <= repeat_cnt_i.
  - R_eff = repeat_cnt_i in that cycle, else R_lat. This covers single-word frames.
- On an accepted read of a word with the last flag set:
  - If pass_cnt < R_eff: rd_ptr <= base_ptr (rewind); pass_cnt + 1.
  - Otherwise: base_ptr <= rd_ptr + 1 (frame freed); rd_ptr + 1; pass_cnt <= 0.
- On an accepted read of a non-last word: rd_ptr + 1.
- If the reader overtakes the writer mid-frame, empty asserts and the read stalls. Replay cannot start until the last word has been written.
- Simultaneous write and read are both accepted.
- full and empty are evaluated on the pre-edge state. A write in the same cycle as a frame-freeing read is still rejected if full was 1.
- R = 0 gives plain FIFO behaviour.
- A frame longer than DEPTH cannot complete. Writes are then rejected and overflow sets. Frames must not exceed DEPTH words; recovery is by flush.
- No combinational path from the inputs to any output except through the status registers.

Test Plan:
- Reset then R=0: write 10 words 1..10 (last on 10), read 10 -> data 1..10 one cycle after each accept, pass_o=0, last only on 10, then empty=1 and level=0.
- R=2: write frame A,B,C (last on C), read 9 -> A,B,C,A,B,C,A,B,C with pass 0,0,0,1,1,1,2,2,2; level stays 3 until the 9th accept, then 0.
- Fill 16 words as two 8-word frames with R=1, write a 17th -> full=1, word dropped, overflow=1; read 8 words (pass 0) -> still full; read 8 more -> full=0 and level=8.
- Single-word frame X with repeat_cnt_i=3 presented on the first read -> X returned 4 times, pass 0..3, last=1 each time; changing repeat_cnt_i to 0 mid-replay has no effect.
- Writer at 1 word per 3 cycles, reader continuous, R=1 -> reader stalls on empty, no valid pulses while empty, rewind only after the last word, data order correct.
- Mid-replay (pass 1 of 2), assert reset_n_i=0 asynchronously -> all outputs at reset values immediately; repeat the sequence with flush_i -> same result on the next edge, overflow cleared.
